// File: rtl/panic_credit_scheduler_pkg.sv
// Shared defaults and helpers for the panic descriptor scheduler and its arbiter.
// No ports: this package holds parameter defaults and a width helper.
package panic_credit_scheduler_pkg;

  localparam int unsigned PANIC_SCHED_ENGINE_NUM   = 4;
  localparam int unsigned PANIC_SCHED_INIT_CREDIT  = 8;
  localparam int unsigned PANIC_SCHED_CREDIT_WIDTH = 4;
  localparam int unsigned PANIC_SCHED_DESC_WIDTH   = 128;
  localparam int unsigned PANIC_SCHED_DEST_WIDTH   = 3;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/panic_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or
// above ptr, wrapping modulo N.
// Ports: request (N), ptr (start index) -> grant (one-hot), grant_idx, grant_valid.
module panic_rr_arbiter
  import panic_credit_scheduler_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int unsigned      idx_wide;
  logic [IDX_W-1:0] idx;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx_wide    = 0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_wide = (32'(ptr) + k) % N;
      idx      = IDX_W'(idx_wide);
      if (!grant_valid && request[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/panic_credit_scheduler.sv
// Credit-based descriptor scheduler: routes each descriptor to an eligible
// engine with credit (round-robin), owns all engine credit counters.
// Ports: s_desc_* (input stream, mask of eligible engines), m_desc_* (output
// stream with crossbar dest), credit_return (per-engine pulses), credit_count
// (live counters), desc_drop (zero-mask pulse), credit_overflow (sticky).
module panic_credit_scheduler
  import panic_credit_scheduler_pkg::*;
#(
  parameter int unsigned ENGINE_NUM        = PANIC_SCHED_ENGINE_NUM,
  parameter int unsigned INIT_CREDIT_NUM   = PANIC_SCHED_INIT_CREDIT,
  parameter int unsigned CREDIT_WIDTH      = PANIC_SCHED_CREDIT_WIDTH,
  parameter int unsigned DESC_WIDTH        = PANIC_SCHED_DESC_WIDTH,
  parameter int unsigned SWITCH_DEST_WIDTH = PANIC_SCHED_DEST_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DESC_WIDTH-1:0]              s_desc_data,
  input  logic [ENGINE_NUM-1:0]              s_desc_mask,
  input  logic                               s_desc_valid,
  output logic                               s_desc_ready,
  output logic [DESC_WIDTH-1:0]              m_desc_data,
  output logic [SWITCH_DEST_WIDTH-1:0]       m_desc_dest,
  output logic                               m_desc_valid,
  input  logic                               m_desc_ready,
  input  logic [ENGINE_NUM-1:0]              credit_return,
  output logic [ENGINE_NUM*CREDIT_WIDTH-1:0] credit_count,
  output logic                               desc_drop,
  output logic                               credit_overflow
);

  localparam int unsigned       PTR_W  = idx_width(ENGINE_NUM);
  localparam logic [CREDIT_WIDTH-1:0] INIT_C = CREDIT_WIDTH'(INIT_CREDIT_NUM);
  localparam logic [PTR_W-1:0]        LAST   = PTR_W'(ENGINE_NUM - 1);

  logic [CREDIT_WIDTH-1:0] credit     [ENGINE_NUM];
  logic [CREDIT_WIDTH-1:0] credit_nxt [ENGINE_NUM];
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        rr_ptr_nxt;
  logic [ENGINE_NUM-1:0]   eligible;
  logic [ENGINE_NUM-1:0]   arb_grant;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic                    out_free;
  logic                    accept;
  logic                    grant_fire;
  logic                    drop_fire;
  logic                    overflow_hit;

  // An engine is eligible only if the descriptor allows it and it holds credit.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      eligible[i] = s_desc_mask[i] & (credit[i] != '0);
    end
  end

  panic_rr_arbiter #(.N(ENGINE_NUM)) u_arb (
    .request     (eligible),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Zero-mask descriptors are always accepted (and dropped) when the output is free.
  assign out_free     = !m_desc_valid | m_desc_ready;
  assign s_desc_ready = out_free & ((eligible != '0) | (s_desc_mask == '0));
  assign accept       = s_desc_valid & s_desc_ready;
  assign grant_fire   = accept & arb_valid;
  assign drop_fire    = accept & (s_desc_mask == '0);
  assign rr_ptr_nxt   = (arb_idx == LAST) ? '0 : arb_idx + PTR_W'(1);

  // Per-engine credit update; a simultaneous grant and return cancel out.
  always_comb begin
    overflow_hit = 1'b0;
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      credit_nxt[i] = credit[i];
      if ((grant_fire && arb_grant[i]) && !credit_return[i]) begin
        credit_nxt[i] = credit[i] - CREDIT_WIDTH'(1);
      end else if (credit_return[i] && !(grant_fire && arb_grant[i])) begin
        if (credit[i] == INIT_C) begin
          overflow_hit = 1'b1;
        end else begin
          credit_nxt[i] = credit[i] + CREDIT_WIDTH'(1);
        end
      end
    end
  end

  // Flatten counters for observation.
  always_comb begin
    credit_count = '0;
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      credit_count[i*CREDIT_WIDTH +: CREDIT_WIDTH] = credit[i];
    end
  end

  // Credit, pointer, output register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
        credit[i] <= INIT_C;
      end
      rr_ptr          <= '0;
      m_desc_valid    <= 1'b0;
      m_desc_data     <= '0;
      m_desc_dest     <= '0;
      desc_drop       <= 1'b0;
      credit_overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
        credit[i] <= credit_nxt[i];
      end
      desc_drop <= drop_fire;
      if (overflow_hit) begin
        credit_overflow <= 1'b1;
      end
      if (grant_fire) begin
        m_desc_valid <= 1'b1;
        m_desc_data  <= s_desc_data;
        m_desc_dest  <= SWITCH_DEST_WIDTH'(arb_idx);
        rr_ptr       <= rr_ptr_nxt;
      end else if (m_desc_ready) begin
        m_desc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_panic_credit_scheduler.sv
// Directed self-checking bench for panic_credit_scheduler.
module tb_panic_credit_scheduler;

  logic         clk;
  logic         rst;
  logic [127:0] s_desc_data;
  logic [3:0]   s_desc_mask;
  logic         s_desc_valid;
  logic         s_desc_ready;
  logic [127:0] m_desc_data;
  logic [2:0]   m_desc_dest;
  logic         m_desc_valid;
  logic         m_desc_ready;
  logic [3:0]   credit_return;
  logic [15:0]  credit_count;
  logic         desc_drop;
  logic         credit_overflow;

  int checks;
  int errors;

  panic_credit_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .s_desc_data     (s_desc_data),
    .s_desc_mask     (s_desc_mask),
    .s_desc_valid    (s_desc_valid),
    .s_desc_ready    (s_desc_ready),
    .m_desc_data     (m_desc_data),
    .m_desc_dest     (m_desc_dest),
    .m_desc_valid    (m_desc_valid),
    .m_desc_ready    (m_desc_ready),
    .credit_return   (credit_return),
    .credit_count    (credit_count),
    .desc_drop       (desc_drop),
    .credit_overflow (credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #90000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    s_desc_data   = '0;
    s_desc_mask   = '0;
    s_desc_valid  = 1'b0;
    m_desc_ready  = 1'b1;
    credit_return = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_credit", 128'(credit_count), 128'(16'h8888));
    check("rst_valid", 128'(m_desc_valid), 128'(0));
    check("rst_drop", 128'(desc_drop), 128'(0));
    check("rst_ovf", 128'(credit_overflow), 128'(0));

    // Four full-mask descriptors rotate through engines 0..3
    for (int k = 0; k < 4; k++) begin
      s_desc_valid = 1'b1;
      s_desc_mask  = 4'b1111;
      s_desc_data  = 128'(32'hA0 + k);
      #1;
      check("rr_ready", 128'(s_desc_ready), 128'(1));
      step();
      check("rr_valid", 128'(m_desc_valid), 128'(1));
      check("rr_dest", 128'(m_desc_dest), 128'(k));
      check("rr_data", 128'(m_desc_data), 128'(32'hA0 + k));
    end
    check("rr_credit", 128'(credit_count), 128'(16'h7777));
    s_desc_valid = 1'b0;
    step();
    check("rr_drain", 128'(m_desc_valid), 128'(0));

    // Fresh credits, then exhaust engine 1
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    check("rst2_credit", 128'(credit_count), 128'(16'h8888));
    for (int k = 0; k < 8; k++) begin
      s_desc_valid = 1'b1;
      s_desc_mask  = 4'b0010;
      s_desc_data  = 128'(32'h100 + k);
      #1;
      check("ex_ready", 128'(s_desc_ready), 128'(1));
      step();
      check("ex_dest", 128'(m_desc_dest), 128'(1));
      check("ex_data", 128'(m_desc_data), 128'(32'h100 + k));
    end
    check("ex_credit0", 128'(credit_count), 128'(16'h8808));
    s_desc_data = 128'(32'h108);
    #1;
    check("ex_block", 128'(s_desc_ready), 128'(0));
    step();
    check("ex_drain", 128'(m_desc_valid), 128'(0));
    check("ex_hold_credit", 128'(credit_count), 128'(16'h8808));
    credit_return = 4'b0010;
    #1;
    check("ex_block2", 128'(s_desc_ready), 128'(0));
    step();
    credit_return = 4'b0000;
    #1;
    check("ret_credit", 128'(credit_count), 128'(16'h8818));
    check("ret_ready", 128'(s_desc_ready), 128'(1));
    step();
    check("ninth_valid", 128'(m_desc_valid), 128'(1));
    check("ninth_dest", 128'(m_desc_dest), 128'(1));
    check("ninth_data", 128'(m_desc_data), 128'(32'h108));
    check("ninth_credit", 128'(credit_count), 128'(16'h8808));

    // Zero-mask descriptor is dropped
    s_desc_mask = 4'b0000;
    s_desc_data = 128'(32'hDEAD);
    #1;
    check("drop_ready", 128'(s_desc_ready), 128'(1));
    step();
    check("drop_pulse", 128'(desc_drop), 128'(1));
    check("drop_novalid", 128'(m_desc_valid), 128'(0));
    check("drop_credit", 128'(credit_count), 128'(16'h8808));
    s_desc_valid = 1'b0;
    step();
    check("drop_end", 128'(desc_drop), 128'(0));

    // Grant to engine 2 with a same-cycle return: credit unchanged, no overflow
    s_desc_valid  = 1'b1;
    s_desc_mask   = 4'b0100;
    s_desc_data   = 128'(32'hAA);
    credit_return = 4'b0100;
    #1;
    check("gr_ready", 128'(s_desc_ready), 128'(1));
    step();
    check("gr_dest", 128'(m_desc_dest), 128'(2));
    check("gr_credit", 128'(credit_count), 128'(16'h8808));
    check("gr_ovf", 128'(credit_overflow), 128'(0));

    // Backpressure for five cycles holds the output
    credit_return = 4'b0000;
    m_desc_ready  = 1'b0;
    s_desc_mask   = 4'b1111;
    s_desc_data   = 128'(32'hBB);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", 128'(s_desc_ready), 128'(0));
      step();
      check("bp_valid", 128'(m_desc_valid), 128'(1));
      check("bp_data", 128'(m_desc_data), 128'(32'hAA));
      check("bp_dest", 128'(m_desc_dest), 128'(2));
    end
    m_desc_ready = 1'b1;
    #1;
    check("bp_release", 128'(s_desc_ready), 128'(1));
    step();
    check("bp_next_dest", 128'(m_desc_dest), 128'(3));
    check("bp_next_data", 128'(m_desc_data), 128'(32'hBB));
    check("bp_next_credit", 128'(credit_count), 128'(16'h7808));
    s_desc_valid = 1'b0;

    // Return at full credit sets the sticky overflow flag
    credit_return = 4'b0001;
    step();
    credit_return = 4'b0000;
    check("ovf_flag", 128'(credit_overflow), 128'(1));
    check("ovf_credit", 128'(credit_count), 128'(16'h7808));
    step();
    check("ovf_sticky", 128'(credit_overflow), 128'(1));

    // Async reset in the middle of a held output
    m_desc_ready = 1'b0;
    s_desc_valid = 1'b1;
    s_desc_mask  = 4'b0001;
    s_desc_data  = 128'(32'hCC);
    step();
    s_desc_valid = 1'b0;
    check("hold_dest", 128'(m_desc_dest), 128'(0));
    step();
    check("hold_valid", 128'(m_desc_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 128'(m_desc_valid), 128'(0));
    check("arst_ovf", 128'(credit_overflow), 128'(0));
    check("arst_credit", 128'(credit_count), 128'(16'h8888));
    #3;
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
